// File: rtl/memory_controller.sv
// Byte-wide RAM port arbiter: serialises 1/2/4-byte loads, stores and instruction fetches
// into per-byte RAM cycles and returns a one-cycle completion pulse to the requester.
module memory_controller #(
    parameter int         ADDR_WIDTH = 32,
    parameter logic [1:0] IO_ADDR_HI = 2'b11
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  roll_back,
    input  logic                  io_buffer_full,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr,
    input  logic                  lsb_load,
    input  logic [ADDR_WIDTH-1:0] load_address,
    input  logic [5:0]            op_type_load,
    output logic                  finish_load,
    output logic [31:0]           data_load,
    input  logic                  lsb_store,
    input  logic [ADDR_WIDTH-1:0] store_address,
    input  logic [31:0]           data_store,
    input  logic [5:0]            op_type_store,
    output logic                  finish_store,
    input  logic                  ifetch_req,
    input  logic [ADDR_WIDTH-1:0] ifetch_addr,
    output logic                  ifetch_done,
    output logic [31:0]           ifetch_data
);
    localparam logic [5:0] OP_LB  = 6'd1;
    localparam logic [5:0] OP_LH  = 6'd2;
    localparam logic [5:0] OP_LW  = 6'd3;
    localparam logic [5:0] OP_LBU = 6'd4;
    localparam logic [5:0] OP_LHU = 6'd5;
    localparam logic [5:0] OP_SB  = 6'd6;
    localparam logic [5:0] OP_SH  = 6'd7;
    localparam logic [5:0] OP_SW  = 6'd8;

    typedef enum logic [2:0] {IDLE, STORE, LOAD, FETCH, DONE} state_t;

    state_t                state;
    logic [2:0]            cnt;
    logic [2:0]            len;
    logic [ADDR_WIDTH-1:0] addr;
    logic [5:0]            op;
    logic [31:0]           wdata;
    logic [31:0]           asm_data;
    logic [7:0]            din_hold;
    logic                  held;
    logic                  last_data;

    logic [2:0]            cnt_nxt;
    logic [ADDR_WIDTH-1:0] addr_nxt;
    logic [31:0]           wshift;
    logic [7:0]            rd_byte;
    logic [31:0]           asm_next;
    logic [31:0]           ext;
    logic                  io_stall;
    logic                  pick_fetch;

    function automatic logic [2:0] len_of(input logic [5:0] o);
        case (o)
            OP_LB, OP_LBU, OP_SB: len_of = 3'd1;
            OP_LH, OP_LHU, OP_SH: len_of = 3'd2;
            default:              len_of = 3'd4;
        endcase
    endfunction

    assign cnt_nxt    = cnt + 3'd1;
    assign addr_nxt   = addr + ADDR_WIDTH'(cnt_nxt);
    assign wshift     = wdata >> {cnt_nxt[1:0], 3'b000};
    assign io_stall   = (addr[17:16] == IO_ADDR_HI) && io_buffer_full;
    assign mem_wr     = (state == STORE) && rdy_in && !io_stall;
    assign pick_fetch = ifetch_req && (!lsb_load || last_data);
    // The RAM keeps running while frozen, so the byte due at resume is parked in din_hold.
    assign rd_byte    = held ? din_hold : mem_din;

    always_comb begin
        asm_next = asm_data;
        case (cnt)
            3'd1:    asm_next[7:0]   = rd_byte;
            3'd2:    asm_next[15:8]  = rd_byte;
            3'd3:    asm_next[23:16] = rd_byte;
            3'd4:    asm_next[31:24] = rd_byte;
            default: ;
        endcase
    end

    always_comb begin
        ext = asm_next;
        case (op)
            OP_LB:   ext = {{24{asm_next[7]}}, asm_next[7:0]};
            OP_LBU:  ext = {24'd0, asm_next[7:0]};
            OP_LH:   ext = {{16{asm_next[15]}}, asm_next[15:0]};
            OP_LHU:  ext = {16'd0, asm_next[15:0]};
            default: ;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state        <= IDLE;
            cnt          <= '0;
            len          <= '0;
            addr         <= '0;
            op           <= '0;
            wdata        <= '0;
            asm_data     <= '0;
            din_hold     <= '0;
            held         <= 1'b0;
            last_data    <= 1'b1;
            mem_a        <= '0;
            mem_dout     <= '0;
            finish_load  <= 1'b0;
            finish_store <= 1'b0;
            ifetch_done  <= 1'b0;
            data_load    <= '0;
            ifetch_data  <= '0;
        end else begin
            finish_load  <= 1'b0;
            finish_store <= 1'b0;
            ifetch_done  <= 1'b0;
            if (!rdy_in) begin
                if ((state == LOAD || state == FETCH) && !held) begin
                    din_hold <= mem_din;
                    held     <= 1'b1;
                end
            end else begin
                held <= 1'b0;
                case (state)
                    IDLE: begin
                        if (lsb_store) begin
                            state    <= STORE;
                            addr     <= store_address;
                            wdata    <= data_store;
                            len      <= len_of(op_type_store);
                            cnt      <= '0;
                            mem_a    <= store_address;
                            mem_dout <= data_store[7:0];
                        end else if (!roll_back && (lsb_load || ifetch_req)) begin
                            cnt      <= '0;
                            asm_data <= '0;
                            if (pick_fetch) begin
                                state     <= FETCH;
                                addr      <= ifetch_addr;
                                mem_a     <= ifetch_addr;
                                op        <= OP_LW;
                                len       <= 3'd4;
                                last_data <= 1'b0;
                            end else begin
                                state     <= LOAD;
                                addr      <= load_address;
                                mem_a     <= load_address;
                                op        <= op_type_load;
                                len       <= len_of(op_type_load);
                                last_data <= 1'b1;
                            end
                        end
                    end
                    STORE: begin
                        if (!io_stall) begin
                            if (cnt == len - 3'd1) begin
                                state        <= DONE;
                                finish_store <= 1'b1;
                            end else begin
                                cnt      <= cnt_nxt;
                                mem_a    <= addr_nxt;
                                mem_dout <= wshift[7:0];
                            end
                        end
                    end
                    LOAD, FETCH: begin
                        if (roll_back) begin
                            state <= IDLE;
                        end else begin
                            asm_data <= asm_next;
                            if (cnt == len) begin
                                state <= DONE;
                                if (state == FETCH) begin
                                    ifetch_done <= 1'b1;
                                    ifetch_data <= asm_next;
                                end else begin
                                    finish_load <= 1'b1;
                                    data_load   <= ext;
                                end
                            end else begin
                                cnt <= cnt_nxt;
                                if (cnt_nxt < len) mem_a <= addr_nxt;
                            end
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_memory_controller.sv
// Scoreboard bench for memory_controller: stimulus pushes expected pulses/writes,
// a negedge monitor pops and compares them against what the DUT presents.
module tb_memory_controller;
    localparam logic [5:0] OP_LB = 6'd1, OP_LH = 6'd2, OP_LW = 6'd3, OP_LBU = 6'd4,
                           OP_LHU = 6'd5, OP_SB = 6'd6, OP_SH = 6'd7, OP_SW = 6'd8;
    localparam int K_LOAD = 0, K_STORE = 1, K_FETCH = 2;

    logic        clk = 1'b0;
    logic        rst_in, rdy_in, roll_back, io_buffer_full;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        lsb_load, finish_load, lsb_store, finish_store, ifetch_req, ifetch_done;
    logic [31:0] load_address, data_load, store_address, data_store, ifetch_addr, ifetch_data;
    logic [5:0]  op_type_load, op_type_store;

    memory_controller dut (
        .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in), .roll_back(roll_back),
        .io_buffer_full(io_buffer_full), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_a(mem_a), .mem_wr(mem_wr), .lsb_load(lsb_load), .load_address(load_address),
        .op_type_load(op_type_load), .finish_load(finish_load), .data_load(data_load),
        .lsb_store(lsb_store), .store_address(store_address), .data_store(data_store),
        .op_type_store(op_type_store), .finish_store(finish_store), .ifetch_req(ifetch_req),
        .ifetch_addr(ifetch_addr), .ifetch_done(ifetch_done), .ifetch_data(ifetch_data)
    );

    always #5 clk = ~clk;

    typedef struct { int kind; logic [31:0] data; } exp_t;
    typedef struct { logic [31:0] a; logic [7:0] d; } wr_t;
    exp_t expq[$];
    wr_t  wq[$];
    int   checks = 0;
    int   errors = 0;
    logic [31:0] alog [0:15];
    bit          wlog [0:15];

    // RAM model: registered read, written bytes override the preload.
    logic [7:0] wmem [0:1023];
    bit         wv   [0:1023];

    function automatic logic [7:0] init_byte(input logic [9:0] a);
        case (a)
            10'h100: init_byte = 8'h11;  10'h101: init_byte = 8'h22;
            10'h102: init_byte = 8'h33;  10'h103: init_byte = 8'h44;
            10'h040: init_byte = 8'h80;  10'h041: init_byte = 8'hFF;
            10'h010: init_byte = 8'h13;  10'h012: init_byte = 8'h50;
            10'h020: init_byte = 8'h93;  10'h022: init_byte = 8'h10;
            default: init_byte = 8'h00;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst_in) begin
            for (int i = 0; i < 1024; i++) wv[i] <= 1'b0;
        end else if (mem_wr) begin
            wmem[mem_a[9:0]] <= mem_dout;
            wv[mem_a[9:0]]   <= 1'b1;
        end
        mem_din <= wv[mem_a[9:0]] ? wmem[mem_a[9:0]] : init_byte(mem_a[9:0]);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        wr_t  w;
        int   n;
        int   k;
        if (!rst_in) begin
            n = int'(finish_load) + int'(finish_store) + int'(ifetch_done);
            if (n != 0) begin
                chk("pulse_exclusive", n, 1);
                k = finish_load ? K_LOAD : finish_store ? K_STORE : K_FETCH;
                if (expq.size() == 0) begin
                    chk("unexpected_pulse_kind", k, 32'hFFFF_FFFF);
                end else begin
                    e = expq.pop_front();
                    chk("pulse_kind", k, e.kind);
                    if (k == K_LOAD)  chk("data_load", data_load, e.data);
                    if (k == K_FETCH) chk("ifetch_data", ifetch_data, e.data);
                end
            end
            if (mem_wr) begin
                if (wq.size() == 0) begin
                    chk("unexpected_write_addr", mem_a, 32'hFFFF_FFFF);
                end else begin
                    w = wq.pop_front();
                    chk("write_addr", mem_a, w.a);
                    chk("write_data", {24'd0, mem_dout}, {24'd0, w.d});
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drop(input int kind);
        if (kind == K_LOAD)  lsb_load = 1'b0;
        if (kind == K_STORE) lsb_store = 1'b0;
        if (kind == K_FETCH) ifetch_req = 1'b0;
    endtask

    task automatic req_load(input logic [31:0] a, input logic [5:0] o, input logic [31:0] exp, input bit push);
        lsb_load = 1'b1; load_address = a; op_type_load = o;
        if (push) expq.push_back('{K_LOAD, exp});
    endtask

    task automatic req_store(input logic [31:0] a, input logic [5:0] o, input logic [31:0] d, input int nbytes);
        lsb_store = 1'b1; store_address = a; op_type_store = o; data_store = d;
        expq.push_back('{K_STORE, 32'd0});
        for (int i = 0; i < nbytes; i++) wq.push_back('{a + 32'(i), d[8*i +: 8]});
    endtask

    task automatic req_fetch(input logic [31:0] a, input logic [31:0] exp);
        ifetch_req = 1'b1; ifetch_addr = a;
        expq.push_back('{K_FETCH, exp});
    endtask

    task automatic run(input int kind, input bit expect_pulse, input int limit, input int rb_at,
                       input int rdy_lo, input int rdy_hi, input int io_clr, output int cyc);
        bit p;
        cyc = 0;
        forever begin
            step();
            cyc++;
            if (cyc < 16) begin alog[cyc] = mem_a; wlog[cyc] = mem_wr; end
            p = (kind == K_LOAD) ? finish_load : (kind == K_STORE) ? finish_store : ifetch_done;
            if (p) begin
                drop(kind);
                if (!expect_pulse) chk("spurious_pulse", {31'd0, p}, 32'd0);
                break;
            end
            roll_back = (cyc == rb_at);
            if (cyc == rb_at && kind != K_STORE) drop(kind);
            if (cyc == rdy_lo) rdy_in = 1'b0;
            if (cyc == rdy_hi) rdy_in = 1'b1;
            if (cyc == io_clr) io_buffer_full = 1'b0;
            if (cyc >= limit) begin
                if (expect_pulse) begin
                    checks++; errors++;
                    $display("FAIL timeout kind %0d: no pulse within %0d cycles", kind, limit);
                end
                drop(kind);
                break;
            end
        end
        roll_back = 1'b0;
    endtask

    initial begin
        int cyc, sc, fc, lc;
        rst_in = 1'b1; rdy_in = 1'b1; roll_back = 1'b0; io_buffer_full = 1'b0;
        lsb_load = 1'b0; load_address = '0; op_type_load = '0;
        lsb_store = 1'b0; store_address = '0; data_store = '0; op_type_store = '0;
        ifetch_req = 1'b0; ifetch_addr = '0;
        #12;
        chk("rst_mem_a", mem_a, 32'd0);
        chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        chk("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
        chk("rst_pulses", {29'd0, finish_load, finish_store, ifetch_done}, 32'd0);
        chk("rst_data_load", data_load, 32'd0);
        step();
        rst_in = 1'b0;
        step();

        // All three at once right after reset: store, then fetch (last grant = data), then load.
        req_store(32'h300, OP_SW, 32'hCAFEF00D, 4);
        req_fetch(32'h20, 32'h00100093);
        req_load(32'h100, OP_LW, 32'h44332211, 1'b0);
        expq.push_back('{K_LOAD, 32'h44332211});
        cyc = 0; sc = 0; fc = 0; lc = 0;
        while (cyc < 60 && (lsb_store || lsb_load || ifetch_req)) begin
            step();
            cyc++;
            if (finish_store) begin sc = cyc; lsb_store = 1'b0; end
            if (ifetch_done)  begin fc = cyc; ifetch_req = 1'b0; end
            if (finish_load)  begin lc = cyc; lsb_load = 1'b0; end
        end
        chk("combo_store_cycle", sc, 5);
        chk("combo_fetch_cycle", fc, 12);
        chk("combo_load_cycle", lc, 19);
        step();

        req_load(32'h100, OP_LW, 32'h44332211, 1'b1);
        run(K_LOAD, 1, 30, -1, -1, -1, -1, cyc);
        chk("lw_latency", cyc, 6);
        for (int i = 0; i < 4; i++) begin
            chk("lw_mem_a", alog[i+1], 32'h100 + 32'(i));
            chk("lw_mem_wr", {31'd0, wlog[i+1]}, 32'd0);
        end
        step();

        req_load(32'h40, OP_LB, 32'hFFFFFF80, 1'b1);
        run(K_LOAD, 1, 30, -1, -1, -1, -1, cyc);
        chk("lb_latency", cyc, 3);
        step();
        req_load(32'h40, OP_LBU, 32'h00000080, 1'b1);
        run(K_LOAD, 1, 30, -1, -1, -1, -1, cyc); step();
        req_load(32'h40, OP_LHU, 32'h0000FF80, 1'b1);
        run(K_LOAD, 1, 30, -1, -1, -1, -1, cyc);
        chk("lhu_latency", cyc, 4);
        step();
        req_load(32'h40, OP_LH, 32'hFFFFFF80, 1'b1);
        run(K_LOAD, 1, 30, -1, -1, -1, -1, cyc); step();

        req_store(32'h200, OP_SH, 32'h1234ABCD, 2);
        run(K_STORE, 1, 30, -1, -1, -1, -1, cyc);
        chk("sh_latency", cyc, 3);
        chk("sh_wr_c1", {31'd0, wlog[1]}, 32'd1);
        chk("sh_wr_c2", {31'd0, wlog[2]}, 32'd1);
        step();
        req_load(32'h200, OP_LHU, 32'h0000ABCD, 1'b1);
        run(K_LOAD, 1, 30, -1, -1, -1, -1, cyc); step();
        req_load(32'h200, OP_LH, 32'hFFFFABCD, 1'b1);
        run(K_LOAD, 1, 30, -1, -1, -1, -1, cyc); step();

        // Flush during the 2nd byte of LW; controller must be idle for the very next request.
        req_load(32'h100, OP_LW, 32'h0, 1'b0);
        run(K_LOAD, 0, 3, 2, -1, -1, -1, cyc);
        req_load(32'h40, OP_LB, 32'hFFFFFF80, 1'b1);
        run(K_LOAD, 1, 30, -1, -1, -1, -1, cyc);
        chk("after_flush_latency", cyc, 3);
        step();

        req_store(32'h304, OP_SW, 32'h01020304, 4);
        run(K_STORE, 1, 30, 2, -1, -1, -1, cyc);
        chk("sw_flush_latency", cyc, 5);
        step();
        req_load(32'h304, OP_LW, 32'h01020304, 1'b1);
        run(K_LOAD, 1, 30, -1, -1, -1, -1, cyc); step();

        // Flush coincident with a load request suppresses that grant for one cycle.
        req_load(32'h100, OP_LW, 32'h44332211, 1'b1);
        roll_back = 1'b1;
        run(K_LOAD, 1, 30, -1, -1, -1, -1, cyc);
        chk("flush_grant_latency", cyc, 7);
        step();

        io_buffer_full = 1'b1;
        req_store(32'h30000, OP_SB, 32'h0000005A, 1);
        run(K_STORE, 1, 30, -1, -1, -1, 4, cyc);
        chk("io_latency", cyc, 5);
        for (int i = 1; i <= 3; i++) chk("io_stall_wr", {31'd0, wlog[i]}, 32'd0);
        step();

        req_fetch(32'h10, 32'h00500013);
        run(K_FETCH, 1, 30, -1, 2, 5, -1, cyc);
        chk("freeze_fetch_latency", cyc, 9);
        rdy_in = 1'b1;
        step();

        // Reset in the middle of an access: no pulse, outputs cleared.
        req_load(32'h100, OP_LW, 32'h0, 1'b0);
        step(); step();
        rst_in = 1'b1;
        #1;
        chk("midrst_finish_load", {31'd0, finish_load}, 32'd0);
        chk("midrst_mem_a", mem_a, 32'd0);
        chk("midrst_data_load", data_load, 32'd0);
        chk("midrst_ifetch_data", ifetch_data, 32'd0);
        lsb_load = 1'b0;
        step();
        rst_in = 1'b0;
        repeat (4) step();

        req_load(32'h41, OP_LB, 32'hFFFFFFFF, 1'b1);
        run(K_LOAD, 1, 30, -1, -1, -1, -1, cyc);
        chk("post_reset_lb_latency", cyc, 3);
        repeat (2) step();

        chk("exp_queue_empty", expq.size(), 32'd0);
        chk("write_queue_empty", wq.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
